// File: rtl/byte_queue_pkg.sv
// Shared types and default sizing for the byte_queue FIFO stage.
package byte_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } q_state_t;

endpackage

// File: rtl/byte_queue_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one asynchronous read port, no reset.
module byte_queue_mem
  import byte_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/byte_queue.sv
// Circular byte FIFO behind the deserializer: data_ready/ack enqueue FSM, explicit dequeue.
// Optional sticky stall flag overflow_out when BYTE_QUEUE_OVERFLOW_FLAG_EN is defined.
module byte_queue
  import byte_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  output logic              ack_out,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  output logic [CNT_W-1:0]  len_out,
  output logic              empty_out,
`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
  output logic              full_out,
  output logic              overflow_out
`else
  output logic              full_out
`endif
);

  q_state_t          state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rd_data_c;
  logic              wr_en_c;
  logic              rd_en_c;

  assign len_out   = count;
  assign empty_out = (count == '0);
  assign full_out  = (count == CNT_W'(DEPTH));

  // Both decisions use the pre-edge count: no bypass when empty, no accept when full.
  assign wr_en_c = (state == IDLE) && enqueue_in && !full_out;
  assign rd_en_c = dequeue_in && !empty_out;

  byte_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk_100mhz),
    .wr_en     (wr_en_c),
    .wr_addr   (wr_ptr),
    .wr_data   (data_in),
    .rd_addr   (rd_ptr),
    .rd_data_c (rd_data_c)
  );

  // Enqueue handshake FSM; WAIT_LOW keeps a lingering data_ready from writing twice.
  always_ff @(posedge clk_100mhz) begin
    if (!reset) begin
      state   <= IDLE;
      ack_out <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      ack_out <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en_c) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            ack_out <= 1'b1;
            state   <= ACK;
          end
        end
        ACK:      state <= WAIT_LOW;
        WAIT_LOW: if (!enqueue_in) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Dequeue path and occupancy.
  always_ff @(posedge clk_100mhz) begin
    if (!reset) begin
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= rd_en_c;
      if (rd_en_c) begin
        data_out <= rd_data_c;
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
    end
  end

`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
  // Sticky record that the deserializer was stalled by a full queue.
  always_ff @(posedge clk_100mhz) begin
    if (!reset) begin
      overflow_out <= 1'b0;
    end else if ((state == IDLE) && enqueue_in && full_out) begin
      overflow_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_queue.sv
// Directed scoreboard bench for byte_queue: stimulus pushes expected bytes, a monitor pops them on data_valid_out.
module tb_byte_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_100mhz = 1'b0;
  logic              reset      = 1'b0;
  logic [DATA_W-1:0] data_in    = '0;
  logic              enqueue_in = 1'b0;
  logic              dequeue_in = 1'b0;
  logic              ack_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic [CNT_W-1:0]  len_out;
  logic              empty_out;
  logic              full_out;
`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
  logic              overflow_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk_100mhz = ~clk_100mhz;

  byte_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_100mhz     (clk_100mhz),
    .reset          (reset),
    .data_in        (data_in),
    .enqueue_in     (enqueue_in),
    .ack_out        (ack_out),
    .dequeue_in     (dequeue_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .len_out        (len_out),
    .empty_out      (empty_out),
`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
    .full_out       (full_out),
    .overflow_out   (overflow_out)
`else
    .full_out       (full_out)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every data_valid_out pulse must match the oldest expected byte.
  always @(negedge clk_100mhz) begin
    if (data_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        check("dequeue_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  // Full handshake: raise data_ready, wait for ack, drop it, let the FSM return to IDLE.
  task automatic enq(input logic [DATA_W-1:0] b);
    bit got = 1'b0;
    data_in    = b;
    enqueue_in = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = ack_out;
    end
    if (!got) check("enq_ack_timeout", 32'(ack_out), 32'd1);
    tick();
    enqueue_in = 1'b0;
    tick();
  endtask

  // Hold dequeue_in for n cycles expecting the listed bytes in order.
  task automatic deq_n(input int n, input logic [DATA_W-1:0] first);
    dequeue_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(first + DATA_W'(i));
      tick();
    end
    dequeue_in = 1'b0;
    tick();
  endtask

  initial begin
    int acks;

    // Reset
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_len",   32'(len_out),   32'd0);
    check("rst_empty", 32'(empty_out), 32'd1);
    check("rst_full",  32'(full_out),  32'd0);
    check("rst_ack",   32'(ack_out),   32'd0);
    check("rst_data",  32'(data_out),  32'h00);

    // Single handshake with data_ready lingering three cycles
    data_in    = 8'h55;
    enqueue_in = 1'b1;
    acks = 0;
    repeat (3) begin
      tick();
      acks += int'(ack_out);
    end
    enqueue_in = 1'b0;
    tick();
    check("one_ack", 32'(acks), 32'd1);
    check("len_1",   32'(len_out), 32'd1);
    enq(8'hA3);
    check("len_2",   32'(len_out), 32'd2);
    deq_n(1, 8'h55);
    deq_n(1, 8'hA3);
    check("empty_after_2", 32'(empty_out), 32'd1);

    // Order and wrap
    for (int i = 1; i <= 8; i++) enq(DATA_W'(i));
    check("full_8",  32'(full_out), 32'd1);
    check("len_8",   32'(len_out),  32'd8);
    for (int i = 1; i <= 3; i++) deq_n(1, DATA_W'(i));
    check("len_5",   32'(len_out),  32'd5);
    for (int i = 9; i <= 11; i++) enq(DATA_W'(i));
    check("full_wrap", 32'(full_out), 32'd1);
    deq_n(8, 8'h04);
    check("empty_drain", 32'(empty_out), 32'd1);
    check("last_data",   32'(data_out),  32'h0B);

    // Full stall
    for (int i = 0; i < 8; i++) enq(8'h10 + DATA_W'(i));
    data_in    = 8'hEE;
    enqueue_in = 1'b1;
    acks = 0;
    repeat (3) begin
      tick();
      acks += int'(ack_out);
    end
    check("stall_no_ack", 32'(acks),    32'd0);
    check("stall_len",    32'(len_out), 32'd8);
`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
    check("overflow_set", 32'(overflow_out), 32'd1);
`endif
    exp_q.push_back(8'h10);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    acks = int'(ack_out);
    for (int i = 0; i < 2 && acks == 0; i++) begin
      tick();
      acks = int'(ack_out);
    end
    check("stall_release_ack", 32'(acks), 32'd1);
    tick();
    enqueue_in = 1'b0;
    tick();
    check("stall_len_after", 32'(len_out), 32'd8);
    deq_n(7, 8'h11);
    deq_n(1, 8'hEE);
    check("empty_after_stall", 32'(empty_out), 32'd1);

    // Dequeue on empty
    dequeue_in = 1'b1;
    repeat (4) tick();
    dequeue_in = 1'b0;
    tick();
    check("empty_deq_data", 32'(data_out), 32'hEE);
    data_in    = 8'h7C;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check("no_bypass_ack", 32'(ack_out), 32'd1);
    tick();
    enqueue_in = 1'b0;
    tick();
    check("no_bypass_len",  32'(len_out),  32'd1);
    check("no_bypass_data", 32'(data_out), 32'hEE);
    deq_n(1, 8'h7C);

    // Reset in the middle of a handshake
    enq(8'hA0);
    enq(8'hA1);
    enq(8'hA2);
    data_in    = 8'hA3;
    enqueue_in = 1'b1;
    tick();
    check("pre_reset_ack", 32'(ack_out), 32'd1);
    reset      = 1'b0;
    enqueue_in = 1'b0;
    tick();
    check("mid_rst_len",   32'(len_out),   32'd0);
    check("mid_rst_ack",   32'(ack_out),   32'd0);
    check("mid_rst_empty", 32'(empty_out), 32'd1);
    check("mid_rst_data",  32'(data_out),  32'h00);
`ifdef BYTE_QUEUE_OVERFLOW_FLAG_EN
    check("overflow_clr", 32'(overflow_out), 32'd0);
`endif
    reset = 1'b1;
    tick();
    enq(8'h42);
    check("post_rst_len", 32'(len_out), 32'd1);
    deq_n(1, 8'h42);

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_queue.md
Name: byte_queue

Overview:
- Downstream stage of the serial-to-byte deserializer.
- Accepts each completed byte via the deserializer's data_ready/ack handshake and stores it in a circular FIFO.
- Hands bytes to the consumer on explicit dequeue requests.
- Provides occupancy and full/empty status so the consumer can pace reads; back-pressures the deserializer when full by withholding ack.

Parameters:
- DEPTH, 8: number of byte slots; must be a power of two, ≥2.
- DATA_W, 8: byte width; matches the deserializer output.
- Derived localparam PTR_W = $clog2(DEPTH); count width = PTR_W+1.

Ports:
- clk_100mhz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk_100mhz rising edge).
- data_in  in  DATA_W  byte from deserializer data_out.
- enqueue_in  in  1  byte-available flag; connects to deserializer data_ready.
- ack_out  out  1  one-cycle accept pulse; connects to deserializer ack_in.
- dequeue_in  in  1  consumer read request.
- data_out  out  DATA_W  last dequeued byte (registered, held until the next dequeue).
- data_valid_out  out  1  one-cycle pulse, aligned with new data_out.
- len_out  out  PTR_W+1  current occupancy, 0..DEPTH.
- empty_out  out  1  len_out == 0.
- full_out  out  1  len_out == DEPTH.

Behaviour:
- Reset (reset=0 at clock edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - FSM=IDLE.
  - ack_out=0, data_out=0, data_valid_out=0.
  - Memory contents are don't-care.
  - Reset mid-handshake aborts it. A byte already written stays lost (count cleared).
- Enqueue FSM:
  - IDLE: if enqueue_in=1 and full_out=0, then mem[wr_ptr]<=data_in, wr_ptr++, ack_out<=1, go to ACK. If enqueue_in=1 and full, stay in IDLE with no ack (stall).
  - ACK: ack_out<=0; go to WAIT_LOW.
  - WAIT_LOW: stay until enqueue_in=0, then go to IDLE. This guarantees exactly one write per deserializer byte even while data_ready lingers after ack.
  - ack_out is registered: it is high for exactly the cycle after the write edge.
- Dequeue:
  - If dequeue_in=1 and count≠0 (sampled before this edge's update): data_out<=mem[rd_ptr], rd_ptr++, data_valid_out<=1 next cycle. Otherwise data_valid_out<=0.
  - Dequeue while empty is ignored: no pulse, data_out unchanged.
  - dequeue_in held high pops one byte per cycle until empty.
- Count update:
  - count += write − read each cycle.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - Full with simultaneous dequeue: enqueue still stalls that cycle (full check uses pre-edge count); it is accepted the next cycle.
  - Empty with simultaneous enqueue: no bypass. The read is ignored; the byte becomes readable the following cycle.
- Pointers wrap modulo DEPTH naturally (PTR_W bits).
- len_out, empty_out and full_out are combinational from count.

Optional Feature:
- Macro BYTE_QUEUE_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output overflow_out (1 bit, reset 0).
  - Set sticky when the FSM is in IDLE with enqueue_in=1 and full_out=1 (a stall occurred).
  - Cleared only by reset.
- Undefined: port and logic absent; stall behaviour identical.

Decomposition:
- Shared package byte_queue_pkg:
  - enum typedef q_state_t {IDLE, ACK, WAIT_LOW}.
  - Default DEPTH/DATA_W constants.
- One natural sub-module: byte_queue_mem (DEPTH×DATA_W register array; write port + read port, no reset).
- Top level holds the FSM, pointers and count.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then 1 → len_out=0, empty_out=1, full_out=0, ack_out=0, data_out=0x00.
- Single handshake: enqueue_in=1 with data_in=0x55, held 3 cycles → exactly one ack_out pulse and len_out=1. After enqueue_in drops, a second enqueue of 0xA3 gives len_out=2.
- Order and wrap:
  - Enqueue 0x01..0x08 → full_out=1.
  - Dequeue 3 → data_out 0x01, 0x02, 0x03, each with a data_valid_out pulse.
  - Enqueue 0x09..0x0B → pointers wrap.
  - Drain 8 → data_out 0x04..0x0B in order; empty_out=1.
- Full stall: with 8 bytes queued, assert enqueue_in=1 with 0xEE → no ack, len_out stays 8. Dequeue once → ack follows within 2 cycles, len_out=8, 0xEE read last.
- Empty dequeue: dequeue_in=1 for 4 cycles on an empty queue → data_valid_out stays 0, data_out unchanged. Same-cycle enqueue of 0x7C and dequeue on empty → len_out=1 and no pulse.
- Reset mid-operation: queue 3 bytes, assert reset=0 during an ACK cycle → next cycle len_out=0, ack_out=0, FSM idle. With BYTE_QUEUE_OVERFLOW_FLAG_EN, overflow_out is also cleared after being set by a stall.
